// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the multiply-accumulate datapath:
//   OPERAND_W  - width of each unsigned multiplier operand
//   PRODUCT_W  - width of the full unsigned product
//   state_e    - accumulate / hold state encoding of dot_product_acc
//   cnt_width  - width of the product counter for a given vector length
// -----------------------------------------------------------------------------
package mac_pkg;

    localparam int OPERAND_W = 4;
    localparam int PRODUCT_W = 8;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // A one-element vector still needs a 1-bit counter so the register exists.
    function automatic int cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/dot_product_acc_if.sv
// -----------------------------------------------------------------------------
// dot_product_acc_if
// Operand-input and result-output handshakes of the dot-product stage.
//   in_valid / in_ready / in_a / in_b      : operand pair stream
//   out_valid / out_ready / out_sum        : completed dot product
// Modports:
//   master - the side that produces operands and consumes results
//   slave  - the dot-product block itself
// -----------------------------------------------------------------------------
interface dot_product_acc_if #(
    parameter int ACC_W = 16
);
    import mac_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [OPERAND_W-1:0] in_a;
    logic [OPERAND_W-1:0] in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     out_sum;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum
    );

endinterface

// File: rtl/dot_product_acc_mult.sv
// -----------------------------------------------------------------------------
// Mult
// Combinational unsigned OPERAND_W x OPERAND_W multiplier.
//   Multiplicand - unsigned operand
//   Multiplier   - unsigned operand
//   Product      - full-width unsigned product
// Built as a shift-and-add array: row gi contributes Multiplicand << gi when
// bit gi of Multiplier is set, and each row adds onto the running total of
// the row above it.
// -----------------------------------------------------------------------------
module Mult
    import mac_pkg::*;
(
    input  logic [OPERAND_W-1:0] Multiplicand,
    input  logic [OPERAND_W-1:0] Multiplier,
    output logic [PRODUCT_W-1:0] Product
);

    for (genvar gi = 0; gi < OPERAND_W; gi++) begin : g_row
        logic [PRODUCT_W-1:0] part;
        logic [PRODUCT_W-1:0] run;

        assign part = Multiplier[gi] ? (PRODUCT_W'(Multiplicand) << gi) : '0;

        if (gi == 0) begin : g_first
            assign run = part;
        end else begin : g_next
            assign run = g_row[gi-1].run + part;
        end
    end

    assign Product = g_row[OPERAND_W-1].run;

endmodule

// File: rtl/dot_product_acc.sv
// -----------------------------------------------------------------------------
// dot_product_acc
// Sums LEN consecutive 4x4-bit products and presents the total on a held
// valid/ready output.
// Parameters:
//   LEN   - products per result (1..256)
//   ACC_W - accumulator / result width, at least 8 + clog2(LEN)
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of dot_product_acc_if (operand in, result out)
// Behaviour: in ACC the block accepts one pair per cycle while in_valid is
// high; the LEN-th accepted product completes the sum, which is latched into
// out_sum and held in HOLD until out_ready. No operand is taken in HOLD.
// -----------------------------------------------------------------------------
module dot_product_acc
    import mac_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    dot_product_acc_if.slave bus
);

    localparam int CNT_W = cnt_width(LEN);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [ACC_W-1:0]     acc_q;
    logic [ACC_W-1:0]     out_sum_q;

    logic [PRODUCT_W-1:0] product;
    logic [ACC_W-1:0]     acc_d;
    logic                 accept;
    logic                 last_pair;

    Mult u_mult (
        .Multiplicand (bus.in_a),
        .Multiplier   (bus.in_b),
        .Product      (product)
    );

    // The product of the pair being accepted joins the sum in the same cycle.
    assign acc_d     = acc_q + ACC_W'(product);
    assign accept    = bus.in_valid && (state_q == ST_ACC);
    assign last_pair = (cnt_q == CNT_W'(LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACC;
            cnt_q     <= '0;
            acc_q     <= '0;
            out_sum_q <= '0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        if (last_pair) begin
                            out_sum_q <= acc_d;
                            acc_q     <= '0;
                            cnt_q     <= '0;
                            state_q   <= ST_HOLD;
                        end else begin
                            acc_q     <= acc_d;
                            cnt_q     <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state_q <= ST_ACC;
                    end
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end

    // Handshake outputs depend only on the state register.
    assign bus.in_ready  = (state_q == ST_ACC);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_sum   = out_sum_q;

endmodule

// File: tb/tb_dot_product_acc.sv
// -----------------------------------------------------------------------------
// tb_dot_product_acc
// Two instances: LEN=4 (directed + random traffic) and LEN=1 (all 256 pairs).
// A reference model per instance watches accepted pairs, groups them into
// vectors of LEN, and pushes each expected sum into a queue; a monitor pops
// and compares whenever a result is consumed.
// -----------------------------------------------------------------------------
module tb_dot_product_acc;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dot_product_acc_if #(.ACC_W(16)) if4 ();
    dot_product_acc_if #(.ACC_W(16)) if1 ();

    dot_product_acc #(.LEN(4), .ACC_W(16)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    dot_product_acc #(.LEN(1), .ACC_W(16)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- reference model, LEN=4 ----------------
    int  part4[$];
    int  exp4[$];
    bit  hold4 = 1'b0;
    int  held4 = 0;

    always @(negedge clk) begin
        chk("in_ready4", if4.in_ready, !hold4);
        chk("out_valid4", if4.out_valid, hold4);
        if (hold4) chk("held_sum4", if4.out_sum, held4);
        if (rst) begin
            hold4 = 1'b0;
            held4 = 0;
            part4.delete();
            exp4.delete();
        end else if (hold4) begin
            if (if4.out_ready) hold4 = 1'b0;
        end else if (if4.in_valid) begin
            part4.push_back(int'(if4.in_a) * int'(if4.in_b));
            if (part4.size() == 4) begin
                held4 = part4.sum();
                exp4.push_back(held4);
                part4.delete();
                hold4 = 1'b1;
            end
        end
    end

    // ---------------- reference model, LEN=1 ----------------
    int  exp1[$];
    bit  hold1 = 1'b0;
    int  held1 = 0;
    int  n_res1 = 0;

    always @(negedge clk) begin
        chk("in_ready1", if1.in_ready, !hold1);
        chk("out_valid1", if1.out_valid, hold1);
        if (hold1) chk("held_sum1", if1.out_sum, held1);
        if (rst) begin
            hold1 = 1'b0;
            held1 = 0;
            exp1.delete();
        end else if (hold1) begin
            if (if1.out_ready) hold1 = 1'b0;
        end else if (if1.in_valid) begin
            held1 = int'(if1.in_a) * int'(if1.in_b);
            exp1.push_back(held1);
            hold1 = 1'b1;
        end
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && if4.out_valid && if4.out_ready) begin
            if (exp4.size() == 0) chk("unexpected_result4", if4.out_sum, -1);
            else                  chk("sum4", if4.out_sum, exp4.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && if1.out_valid && if1.out_ready) begin
            n_res1++;
            if (exp1.size() == 0) chk("unexpected_result1", if1.out_sum, -1);
            else                  chk("sum1", if1.out_sum, exp1.pop_front());
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a pair and hold it until the edge that accepts it.
    task automatic send4(input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        if4.in_valid = 1'b1;
        if4.in_a     = a;
        if4.in_b     = b;
        @(negedge clk);
        while (!if4.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send4_timeout", if4.in_ready, 1);
        tick();
    endtask

    task automatic send1(input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        if1.in_valid = 1'b1;
        if1.in_a     = a;
        if1.in_b     = b;
        @(negedge clk);
        while (!if1.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send1_timeout", if1.in_ready, 1);
        tick();
    endtask

    // Wait (bounded) for a result on the LEN=4 instance and check its value.
    task automatic expect4(input string name, input int val);
        int n = 0;
        @(negedge clk);
        while (!if4.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, if4.out_valid ? int'(if4.out_sum) : -1, val);
        $display("result %s sum=%0d expected=%0d", name, if4.out_sum, val);
    endtask

    bit done4 = 1'b0;

    initial begin
        rst = 1'b1;
        repeat (2) begin
            if4.in_valid  = 1'($urandom);
            if4.in_a      = 4'($urandom);
            if4.in_b      = 4'($urandom);
            if4.out_ready = 1'($urandom);
            if1.in_valid  = 1'($urandom);
            if1.in_a      = 4'($urandom);
            if1.in_b      = 4'($urandom);
            if1.out_ready = 1'($urandom);
            tick();
        end
        rst           = 1'b0;
        if4.in_valid  = 1'b0;
        if1.in_valid  = 1'b0;
        if4.out_ready = 1'b1;
        if1.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready4", if4.in_ready, 1);
        chk("rst_out_valid4", if4.out_valid, 0);
        chk("rst_out_sum4", if4.out_sum, 0);
        chk("rst_in_ready1", if1.in_ready, 1);
        chk("rst_out_valid1", if1.out_valid, 0);
        chk("rst_out_sum1", if1.out_sum, 0);
        tick();

        // Basic dot product: 1*5+2*6+3*7+4*8 = 70, single-cycle pulse
        send4(1, 5); send4(2, 6); send4(3, 7); send4(4, 8);
        if4.in_valid = 1'b0;
        expect4("basic", 70);
        @(negedge clk);
        chk("basic_pulse_len", if4.out_valid, 0);
        tick();

        // Maximum operands, then zeros straight after
        fork
            expect4("max", 900);
            begin
                repeat (4) send4(15, 15);
                repeat (4) send4(0, 0);
                if4.in_valid = 1'b0;
            end
        join
        expect4("zero_after_max", 0);
        tick();

        // Backpressure: result held, nothing consumed while out_ready=0
        if4.out_ready = 1'b0;
        repeat (4) send4(1, 1);
        if4.in_valid = 1'b1;
        if4.in_a     = 4'd2;
        if4.in_b     = 4'd1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", if4.in_ready, 0);
            chk("bp_out_valid", if4.out_valid, 1);
            chk("bp_out_sum", if4.out_sum, 4);
        end
        tick();
        if4.out_ready = 1'b1;
        repeat (4) send4(2, 1);
        if4.in_valid = 1'b0;
        expect4("bp_next", 8);
        tick();

        // Gaps, then reset mid-vector discards the partial sum
        send4(2, 3);
        if4.in_valid = 1'b0;
        repeat (3) tick();
        send4(4, 4);
        if4.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) send4(1, 1);
        if4.in_valid = 1'b0;
        expect4("after_rst", 4);
        tick();

        // Random traffic on LEN=4 alongside the exhaustive LEN=1 sweep
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    send4(4'($urandom), 4'($urandom));
                    if4.in_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) tick();
                end
                done4 = 1'b1;
            end
            begin
                while (!done4) begin
                    if4.out_ready = 1'($urandom);
                    tick();
                end
                if4.out_ready = 1'b1;
            end
            begin
                if1.out_ready = 1'b1;
                for (int a = 0; a < 16; a++) begin
                    for (int b = 0; b < 16; b++) begin
                        send1(4'(a), 4'(b));
                    end
                end
                if1.in_valid = 1'b0;
            end
        join

        repeat (10) tick();
        chk("drain4", exp4.size(), 0);
        chk("drain1", exp1.size(), 0);
        chk("count1", n_res1, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_product_acc.md
# dot_product_acc

Sequential dot-product stage built directly downstream of the combinational 4×4 multiplier `Mult`. It accepts a stream of 4-bit operand pairs over a valid/ready handshake and passes each pair through an instantiated `Mult`. It accumulates `LEN` consecutive 8-bit products into a wide accumulator, then presents the sum on a held valid/ready output port. The block turns the lab's single-cycle multiplier into a reusable multiply-accumulate datapath.

## Interface
- `LEN`, default 4: number of products summed per result; legal range is 1 to 256.
- `ACC_W`, default 16: accumulator and result width; must satisfy ACC_W ≥ 8 + clog2(LEN).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair on `in_a`/`in_b` is valid.
- `in_ready`  out  1  block can accept an operand pair this cycle.
- `in_a`  in  4  unsigned operand, driven to `Mult.Multiplicand`.
- `in_b`  in  4  unsigned operand, driven to `Mult.Multiplier`.
- `out_valid`  out  1  `out_sum` holds a completed dot product.
- `out_ready`  in  1  downstream consumes `out_sum` this cycle.
- `out_sum`  out  ACC_W  unsigned sum of `LEN` products.

## Operation
- **Accept rule:** a pair is accepted on a rising edge where `in_valid && in_ready`. `in_valid` may toggle freely, and idle cycles between accepts are allowed.
- **FSM state ACC:**
  - `in_ready`=1, `out_valid`=0.
  - On accept with `cnt` < LEN−1: `acc` ← `acc` + zext(`Product`), `cnt` ← `cnt`+1.
  - On accept with `cnt` == LEN−1:
    - `out_sum` ← `acc` + zext(`Product`);
    - `acc` ← 0, `cnt` ← 0;
    - next state HOLD.
- **FSM state HOLD:**
  - `in_ready`=0, `out_valid`=1, `out_sum` stable.
  - When `out_ready`=1: next state ACC, and `out_valid` drops on the following cycle.
  - No operand is accepted in HOLD, even if `out_ready`=1 in the same cycle.
- **Arithmetic:**
  - Unsigned throughout; each product is zero-extended from 8 bits to ACC_W.
  - Addition wraps modulo 2^ACC_W; no saturation and no overflow flag.
  - Under the parameter rule above, wrap cannot occur.
- **`cnt` width:** max(1, clog2(LEN)) bits. For LEN=1, every accept goes directly to HOLD.
- **Reset:**
  - State ← ACC, `acc` ← 0, `cnt` ← 0, `out_sum` ← 0.
  - Outputs after reset: `out_valid`=0, `in_ready`=1.
  - Reset mid-accumulation or in HOLD discards all partial and held data, with no output pulse.
  - `rst` has priority over any simultaneous handshake.
- **Combinational outputs:** `in_ready` and `out_valid` are pure decodes of the state register, with no combinational path from inputs.

## Timing
- `Mult` is combinational; its product is summed in the same cycle the pair is accepted.
- Latency: `out_valid` rises the cycle after the edge that accepts the LEN-th pair.
- Peak throughput: one result per LEN+1 cycles when `out_ready` is tied high (LEN accept cycles plus one HOLD cycle).
- Backpressure: while `out_ready`=0 in HOLD, `out_sum` and `out_valid` stay constant indefinitely.
- Input stall: `in_valid`=0 in ACC leaves `acc` and `cnt` unchanged.

## Structure
- **Shared package `mac_pkg`:**
  - `OPERAND_W`=4 and `PRODUCT_W`=8;
  - state encoding `ST_ACC`=1'b0, `ST_HOLD`=1'b1.
- **Sub-module:** one instance of the existing `Mult` (ports `Multiplicand`, `Multiplier`, `Product`). No other sub-modules.
- **Registers:**
  - state (1 bit);
  - `cnt`;
  - `acc` (ACC_W bits);
  - `out_sum` (ACC_W bits).

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with random inputs → `in_ready`=1, `out_valid`=0, `out_sum`=0.
- **Basic dot product:** LEN=4, pairs (1,5),(2,6),(3,7),(4,8) on consecutive cycles, `out_ready`=1 → `out_valid` high for exactly 1 cycle, `out_sum`=70, one cycle after the 4th accept.
- **Maximum operands:** LEN=4, all pairs (15,15) → `out_sum`=900.
  - Then immediately (0,0)×4 → `out_sum`=0, proving `acc` cleared.
- **Backpressure:** `out_ready`=0 for 5 cycles after a result, `in_valid`=1 throughout → `out_sum`/`out_valid` held, `in_ready`=0.
  - No pairs are consumed until one cycle after `out_ready`=1.
- **Gaps and reset mid-operation:**
  - Pairs (2,3) and (4,4) separated by 3 idle cycles.
  - Assert `rst` after the 2nd pair.
  - Then feed (1,1)×4 → `out_sum`=4, not 26.
- **LEN=1 and exhaustive check:** all 256 (a,b) pairs with `out_ready`=1 → every result equals a*b, one result every 2 cycles, with zero mismatches against an integer model.
